alu_issue_arbiter: RTL and testbench
====================================

# alu_issue_arbiter

Sequencer and two-port arbiter in front of the single-cycle ALU datapath (integer add/move, FSGNJ/FSGNJN/FSGNJX, FCVT.W.S/WU.S/S.W/S.WU, FCLASS).
- Two requesters (port 0: integer pipe, port 1: FP pipe) present commands with valid/ready handshakes.
- The block grants one request at a time with round-robin priority and registers command and operands so the ALU sees stable inputs for a full cycle.
- It returns the result with requester id and tag on one valid/ready response port.

## Interface
- TAG_W, 4, width of the requester-supplied transaction tag
- clk_i  in  1  clock; everything on rising edge
- rst_i  in  1  synchronous active-high reset
- req0_valid_i  in  1  requester 0 command valid
- req0_ready_o  out  1  requester 0 command accepted this cycle
- req0_cmd_i  in  8  requester 0 ALU command code
- req0_rs1_i, req0_rs2_i  in  32 each  requester 0 operands
- req0_tag_i  in  TAG_W  requester 0 tag
- req1_valid_i, req1_ready_o, req1_cmd_i, req1_rs1_i, req1_rs2_i, req1_tag_i  same as port 0, for requester 1
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumer ready
- rsp_id_o  out  1  requester that issued the op
- rsp_tag_o  out  TAG_W  tag echoed from the request
- rsp_data_o  out  32  ALU result
- rsp_zero_o  out  1  rsp_data_o == 0
- rsp_illegal_o  out  1  command code not in the legal set
- busy_o  out  1  FSM not in IDLE

## Operation
- Legal commands: 1, 2, 3, 74, 75, 76, 79, 80, 85, 86, 87. Any other code is illegal: data = 0, illegal = 1, zero = 1.
- FSM states and transitions:
  - IDLE: if any valid, grant one requester and go to EXEC; otherwise stay.
  - EXEC: registered cmd/rs1/rs2 drive the ALU; result, zero and illegal are captured into response registers; go to RESP.
  - RESP: rsp_valid_o = 1; on rsp_ready_i go to IDLE, otherwise hold.
- Arbitration:
  - reqN_ready_o = (state == IDLE) && grant == N.
  - If only one requester is valid, it is granted.
  - If both are valid, the rr_ptr side is granted.
  - On every grant, rr_ptr <= the other requester.
- Handshake:
  - A transfer occurs on valid && ready.
  - Requesters hold valid and payload stable until ready.
  - ready may be low while valid is high for any number of cycles.
- Response:
  - Fields are stable while rsp_valid_o = 1 and rsp_ready_i = 0.
  - No new request is accepted until the response completes.
- ALU inputs hold their last registered values outside EXEC. The ALU's internal op-select state therefore never sees a mid-cycle command change.
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o, rsp_zero_o, rsp_illegal_o, busy_o all 0.
  - Both ready outputs 0 during the reset cycle.
- Reset mid-operation: an in-flight op is discarded and no response is emitted. Requesters are expected to reset with the block.

## Timing
- Request accepted at cycle T → rsp_valid_o = 1 at T+2.
- With rsp_ready_i = 1 at T+2, the next accept can happen at T+3. Peak throughput is one op per 3 cycles.
- reqN_ready_o is combinational from both reqX_valid_i, state and rr_ptr. There is no path from rsp_ready_i to reqN_ready_o.
- All other outputs are registered.
- Starvation bound: a held request is granted within 2 grants.

## Structure
- The shared package alu_pkg holds:
  - command localparams (ALU_ADD = 1, ALU_MV0 = 2, ALU_MV1 = 3, FSGNJ = 74, FSGNJN = 75, FSGNJX = 76, FCVT_W_S = 79, FCVT_WU_S = 80, FCLASS = 85, FCVT_S_W = 86, FCVT_S_WU = 87);
  - the FSM state encoding;
  - an is_legal_cmd function.
- One sub-module, rr_arb2: a two-input round-robin arbiter with valid inputs, one-hot grant output, and an rr_ptr register updated on an accept strobe.
- The ALU datapath is instantiated once inside this block.

## Test plan
- Requester 0 only, cmd 1, rs1 = 5, rs2 = 7, tag 3 → rsp at T+2: data = 12, id = 0, tag = 3, zero = 0, illegal = 0.
- Both valid from reset, 4 ops each → grants alternate 0,1,0,1,…; response ids match; tags are echoed in order.
- Requester 1, cmd 75 (FSGNJN), rs1 = 0x3F800000, rs2 = 0x3F800000, rsp_ready_i low for 5 cycles → data 0xBF800000 held stable; no ready asserted until the response completes.
- Requester 0, cmd 0x20 (illegal) → data = 0, illegal = 1, zero = 1. A following cmd 2 with rs1 = 0 → data = 0, zero = 1, illegal = 0.
- rst_i asserted in EXEC and in RESP → next cycle state = IDLE, rsp_valid_o = 0, rr_ptr = 0, no response is ever emitted for the aborted op.
- Requester 0, cmd 79, rs1 = 0xC0400000 (−3.0) → data 0xFFFFFFFD. Then cmd 85 with rs1 = 0x7F800000 → data 0x00000080 (+inf class).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue arbiter: widths, command codes, FSM encoding.
package alu_pkg;

   localparam int unsigned TAG_W  = 4;
   localparam int unsigned CMD_W  = 8;
   localparam int unsigned DATA_W = 32;

   localparam logic [CMD_W-1:0] ALU_ADD   = 8'd1;
   localparam logic [CMD_W-1:0] ALU_MV0   = 8'd2;
   localparam logic [CMD_W-1:0] ALU_MV1   = 8'd3;
   localparam logic [CMD_W-1:0] FSGNJ     = 8'd74;
   localparam logic [CMD_W-1:0] FSGNJN    = 8'd75;
   localparam logic [CMD_W-1:0] FSGNJX    = 8'd76;
   localparam logic [CMD_W-1:0] FCVT_W_S  = 8'd79;
   localparam logic [CMD_W-1:0] FCVT_WU_S = 8'd80;
   localparam logic [CMD_W-1:0] FCLASS    = 8'd85;
   localparam logic [CMD_W-1:0] FCVT_S_W  = 8'd86;
   localparam logic [CMD_W-1:0] FCVT_S_WU = 8'd87;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Granted command and operands, held stable in front of the ALU.
   typedef struct packed {
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] rs1;
      logic [DATA_W-1:0] rs2;
      logic [TAG_W-1:0]  tag;
      logic              id;
   } op_t;

   function automatic logic is_legal_cmd(input logic [CMD_W-1:0] cmd);
      case (cmd)
         ALU_ADD, ALU_MV0, ALU_MV1, FSGNJ, FSGNJN, FSGNJX,
         FCVT_W_S, FCVT_WU_S, FCLASS, FCVT_S_W, FCVT_S_WU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Requester command ports and response port of the ALU issue arbiter.
interface alu_issue_arbiter_if;
   import alu_pkg::*;

   logic              req0_valid_i;
   logic              req0_ready_o;
   logic [CMD_W-1:0]  req0_cmd_i;
   logic [DATA_W-1:0] req0_rs1_i;
   logic [DATA_W-1:0] req0_rs2_i;
   logic [TAG_W-1:0]  req0_tag_i;

   logic              req1_valid_i;
   logic              req1_ready_o;
   logic [CMD_W-1:0]  req1_cmd_i;
   logic [DATA_W-1:0] req1_rs1_i;
   logic [DATA_W-1:0] req1_rs2_i;
   logic [TAG_W-1:0]  req1_tag_i;

   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic              rsp_id_o;
   logic [TAG_W-1:0]  rsp_tag_o;
   logic [DATA_W-1:0] rsp_data_o;
   logic              rsp_zero_o;
   logic              rsp_illegal_o;
   logic              busy_o;

   modport master (
      output req0_valid_i, req0_cmd_i, req0_rs1_i, req0_rs2_i, req0_tag_i,
      output req1_valid_i, req1_cmd_i, req1_rs1_i, req1_rs2_i, req1_tag_i,
      output rsp_ready_i,
      input  req0_ready_o, req1_ready_o,
      input  rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o, rsp_zero_o, rsp_illegal_o, busy_o
   );

   modport slave (
      input  req0_valid_i, req0_cmd_i, req0_rs1_i, req0_rs2_i, req0_tag_i,
      input  req1_valid_i, req1_cmd_i, req1_rs1_i, req1_rs2_i, req1_tag_i,
      input  rsp_ready_i,
      output req0_ready_o, req1_ready_o,
      output rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_data_o, rsp_zero_o, rsp_illegal_o, busy_o
   );

endinterface

// File: rtl/alu_dp.sv
// Single-cycle integer/FP-bit-manipulation ALU datapath (purely combinational).
module alu_dp
   import alu_pkg::*;
(
   input  logic [CMD_W-1:0]  cmd_i,
   input  logic [DATA_W-1:0] rs1_i,
   input  logic [DATA_W-1:0] rs2_i,
   output logic [DATA_W-1:0] data_o,
   output logic              illegal_o
);

   // Single to 32-bit integer, truncating, saturating; NaN maps to the max value.
   function automatic logic [31:0] f2i(input logic [31:0] f, input logic uns);
      logic [7:0]  e;
      logic [63:0] mag;
      logic        is_nan;
      logic [31:0] res;
      e      = f[30:23];
      is_nan = (e == 8'hFF) && (f[22:0] != 23'd0);
      mag    = '0;
      if ((e >= 8'd127) && (e <= 8'd158))
         mag = ({40'd0, 1'b1, f[22:0]} << (e - 8'd127)) >> 23;
      else if (e > 8'd158)
         mag = '1;
      if (is_nan)                     res = uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      else if (uns && f[31])          res = '0;
      else if (uns)                   res = (mag > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : mag[31:0];
      else if (f[31])                 res = (mag > 64'h8000_0000) ? 32'h8000_0000 : -mag[31:0];
      else                            res = (mag > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : mag[31:0];
      return res;
   endfunction

   // 32-bit integer to single, round to nearest even.
   function automatic logic [31:0] i2f(input logic [31:0] x, input logic uns);
      logic        neg;
      logic [31:0] mag;
      logic [32:0] rem;
      logic [32:0] half;
      logic [24:0] man;
      logic [7:0]  e;
      logic [31:0] res;
      int          p;
      int          sh;
      neg = !uns && x[31];
      mag = neg ? -x : x;
      p   = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      e   = 8'(127 + p);
      if (p <= 23) begin
         man = 25'(mag << (23 - p));
      end else begin
         sh   = p - 23;
         man  = 25'(mag >> sh);
         rem  = {1'b0, mag} & ((33'd1 << sh) - 33'd1);
         half = 33'd1 << (sh - 1);
         if ((rem > half) || ((rem == half) && man[0])) man = man + 25'd1;
         if (man[24]) begin
            man = man >> 1;
            e   = e + 8'd1;
         end
      end
      res = (mag == 32'd0) ? 32'd0 : {neg, e, man[22:0]};
      return res;
   endfunction

   // RISC-V style class mask.
   function automatic logic [31:0] fclass(input logic [31:0] f);
      logic       s;
      logic       e_max;
      logic       e_zero;
      logic       f_zero;
      logic [9:0] c;
      s      = f[31];
      e_max  = &f[30:23];
      e_zero = ~|f[30:23];
      f_zero = ~|f[22:0];
      c[0] = s  & e_max & f_zero;
      c[1] = s  & !e_max & !e_zero;
      c[2] = s  & e_zero & !f_zero;
      c[3] = s  & e_zero & f_zero;
      c[4] = !s & e_zero & f_zero;
      c[5] = !s & e_zero & !f_zero;
      c[6] = !s & !e_max & !e_zero;
      c[7] = !s & e_max & f_zero;
      c[8] = e_max & !f_zero & !f[22];
      c[9] = e_max & f[22];
      return {22'd0, c};
   endfunction

   // Op select; illegal codes produce zero.
   always_comb begin
      data_o    = '0;
      illegal_o = !is_legal_cmd(cmd_i);
      case (cmd_i)
         ALU_ADD:   data_o = rs1_i + rs2_i;
         ALU_MV0:   data_o = rs1_i;
         ALU_MV1:   data_o = rs2_i;
         FSGNJ:     data_o = {rs2_i[31], rs1_i[30:0]};
         FSGNJN:    data_o = {~rs2_i[31], rs1_i[30:0]};
         FSGNJX:    data_o = {rs1_i[31] ^ rs2_i[31], rs1_i[30:0]};
         FCVT_W_S:  data_o = f2i(rs1_i, 1'b0);
         FCVT_WU_S: data_o = f2i(rs1_i, 1'b1);
         FCLASS:    data_o = fclass(rs1_i);
         FCVT_S_W:  data_o = i2f(rs1_i, 1'b0);
         FCVT_S_WU: data_o = i2f(rs1_i, 1'b1);
         default:   data_o = '0;
      endcase
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer flips to the other side on each accept.
module rr_arb2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] valid_i,
   input  logic       accept_i,
   output logic [1:0] grant_o
);

   logic rr_ptr_q;
   logic rr_ptr_d;

   // Lone requester wins; on contention the pointer side wins.
   always_comb begin
      grant_o  = valid_i;
      if (&valid_i) grant_o = rr_ptr_q ? 2'b10 : 2'b01;
      rr_ptr_d = rr_ptr_q;
      if (accept_i) rr_ptr_d = grant_o[0];
   end

   // Pointer register.
   always_ff @(posedge clk_i) begin
      if (rst_i) rr_ptr_q <= 1'b0;
      else       rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of two requesters into one registered ALU op, with a held response.
module alu_issue_arbiter
   import alu_pkg::*;
(
   input logic                clk_i,
   input logic                rst_i,
   alu_issue_arbiter_if.slave bus
);

   state_e            state_q, state_d;
   op_t               op_q, op_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_illegal_q, rsp_illegal_d;
   logic              busy_q, busy_d;

   logic [1:0]        req_valid;
   logic [1:0]        grant;
   logic              idle;
   logic              accept;
   logic [DATA_W-1:0] alu_data;
   logic              alu_illegal;

   assign req_valid = {bus.req1_valid_i, bus.req0_valid_i};
   assign idle      = (state_q == ST_IDLE) && !rst_i;
   assign accept    = idle && (|grant);

   rr_arb2 u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .valid_i  (req_valid),
      .accept_i (accept),
      .grant_o  (grant)
   );

   alu_dp u_alu (
      .cmd_i     (op_q.cmd),
      .rs1_i     (op_q.rs1),
      .rs2_i     (op_q.rs2),
      .data_o    (alu_data),
      .illegal_o (alu_illegal)
   );

   assign bus.req0_ready_o  = idle && grant[0];
   assign bus.req1_ready_o  = idle && grant[1];
   assign bus.rsp_valid_o   = rsp_valid_q;
   assign bus.rsp_id_o      = rsp_id_q;
   assign bus.rsp_tag_o     = rsp_tag_q;
   assign bus.rsp_data_o    = rsp_data_q;
   assign bus.rsp_zero_o    = rsp_zero_q;
   assign bus.rsp_illegal_o = rsp_illegal_q;
   assign bus.busy_o        = busy_q;

   // IDLE captures the granted op, EXEC captures the ALU result, RESP holds until taken.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_tag_d     = rsp_tag_q;
      rsp_data_d    = rsp_data_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_illegal_d = rsp_illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (grant[1])
                  op_d = '{cmd: bus.req1_cmd_i, rs1: bus.req1_rs1_i, rs2: bus.req1_rs2_i,
                           tag: bus.req1_tag_i, id: 1'b1};
               else
                  op_d = '{cmd: bus.req0_cmd_i, rs1: bus.req0_rs1_i, rs2: bus.req0_rs2_i,
                           tag: bus.req0_tag_i, id: 1'b0};
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_data_d    = alu_data;
            rsp_zero_d    = (alu_data == '0);
            rsp_illegal_d = alu_illegal;
            rsp_id_d      = op_q.id;
            rsp_tag_d     = op_q.tag;
            rsp_valid_d   = 1'b1;
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, op and response registers; reset discards any in-flight op.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_tag_q     <= '0;
         rsp_data_q    <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_illegal_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_tag_q     <= rsp_tag_d;
         rsp_data_q    <= rsp_data_d;
         rsp_zero_q    <= rsp_zero_d;
         rsp_illegal_q <= rsp_illegal_d;
         busy_q        <= busy_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a response scoreboard.
module tb_alu_issue_arbiter;
   import alu_pkg::*;

   typedef struct {
      logic             id;
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic             ill;
   } exp_t;

   typedef struct {
      logic [7:0]       cmd;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
      logic [31:0]      xd;
   } stim_t;

   logic  clk = 1'b0;
   logic  rst;
   int    checks = 0;
   int    failures = 0;
   exp_t  exp_q[$];
   stim_t ops0[4];
   stim_t ops1[4];

   alu_issue_arbiter_if bus();

   alu_issue_arbiter dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
      end
   endtask

   task automatic drive(input bit port, input bit v, input logic [7:0] cmd,
                        input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
      if (port == 1'b0) begin
         bus.req0_valid_i = v; bus.req0_cmd_i = cmd; bus.req0_rs1_i = a;
         bus.req0_rs2_i = b; bus.req0_tag_i = tag;
      end else begin
         bus.req1_valid_i = v; bus.req1_cmd_i = cmd; bus.req1_rs1_i = a;
         bus.req1_rs2_i = b; bus.req1_tag_i = tag;
      end
   endtask

   // Present one op on a port, optionally record its expected response, wait for acceptance.
   task automatic issue(input bit port, input logic [7:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic [31:0] xd, input bit xill, input bit push, output int waited);
      bit got;
      drive(port, 1'b1, cmd, a, b, tag);
      if (push) exp_q.push_back('{id: port, tag: tag, data: xd, ill: xill});
      got    = 1'b0;
      waited = 0;
      while (!got && waited < 20) begin
         @(negedge clk);
         got = port ? bus.req1_ready_o : bus.req0_ready_o;
         @(posedge clk); #1;
         if (!got) waited++;
      end
      chk("accept_in_time", 32'(got), 32'd1);
      drive(port, 1'b0, 8'd0, 32'd0, 32'd0, '0);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Scoreboard: every completed response handshake must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
         chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_id",      32'(bus.rsp_id_o),      32'(e.id));
            chk("rsp_tag",     32'(bus.rsp_tag_o),     32'(e.tag));
            chk("rsp_data",    bus.rsp_data_o,         e.data);
            chk("rsp_zero",    32'(bus.rsp_zero_o),    32'(e.data == 32'd0));
            chk("rsp_illegal", 32'(bus.rsp_illegal_o), 32'(e.ill));
         end
      end
   end

   initial begin
      int w;
      int i0;
      int i1;
      int cyc;
      bit r0;
      bit r1;

      // Reset with both requesters already asserting valid.
      rst = 1'b1;
      bus.rsp_ready_i = 1'b1;
      drive(1'b0, 1'b1, ALU_ADD, 32'd1, 32'd2, 4'd1);
      drive(1'b1, 1'b1, ALU_ADD, 32'd3, 32'd4, 4'd2);
      @(negedge clk);
      chk("rst_ready0",      32'(bus.req0_ready_o),  32'd0);
      chk("rst_ready1",      32'(bus.req1_ready_o),  32'd0);
      chk("rst_rsp_valid",   32'(bus.rsp_valid_o),   32'd0);
      chk("rst_rsp_id",      32'(bus.rsp_id_o),      32'd0);
      chk("rst_rsp_tag",     32'(bus.rsp_tag_o),     32'd0);
      chk("rst_rsp_data",    bus.rsp_data_o,         32'd0);
      chk("rst_rsp_zero",    32'(bus.rsp_zero_o),    32'd0);
      chk("rst_rsp_illegal", 32'(bus.rsp_illegal_o), 32'd0);
      chk("rst_busy",        32'(bus.busy_o),        32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, '0);
      drive(1'b1, 1'b0, 8'd0, 32'd0, 32'd0, '0);
      rst = 1'b0;

      // Single add with latency check, then an immediate back-to-back accept.
      issue(1'b0, ALU_ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0, 1'b1, w);
      @(negedge clk);
      chk("t1_no_rsp_yet", 32'(bus.rsp_valid_o), 32'd0);
      chk("t1_busy",       32'(bus.busy_o),      32'd1);
      @(negedge clk);
      chk("t1_rsp_at_t2",  32'(bus.rsp_valid_o), 32'd1);
      @(posedge clk); #1;
      issue(1'b0, ALU_MV0, 32'd0, 32'h1234, 4'd4, 32'd0, 1'b0, 1'b1, w);
      chk("back_to_back_wait", 32'(w), 32'd0);
      drain();

      // Response stall: data held, no new accept while requester 0 waits.
      bus.rsp_ready_i = 1'b0;
      issue(1'b1, FSGNJN, 32'h3F80_0000, 32'h3F80_0000, 4'd5, 32'hBF80_0000, 1'b0, 1'b1, w);
      drive(1'b0, 1'b1, 8'h20, 32'h11, 32'h22, 4'd6);
      @(negedge clk);
      chk("stall_ready0_exec", 32'(bus.req0_ready_o), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_rsp_valid", 32'(bus.rsp_valid_o),  32'd1);
         chk("stall_rsp_data",  bus.rsp_data_o,        32'hBF80_0000);
         chk("stall_ready0",    32'(bus.req0_ready_o), 32'd0);
      end
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b1;
      issue(1'b0, 8'h20, 32'h11, 32'h22, 4'd6, 32'd0, 1'b1, 1'b1, w);
      issue(1'b0, ALU_MV0, 32'd0, 32'h55, 4'd7, 32'd0, 1'b0, 1'b1, w);
      issue(1'b0, FCVT_W_S, 32'hC040_0000, 32'd0, 4'd8, 32'hFFFF_FFFD, 1'b0, 1'b1, w);
      issue(1'b0, FCLASS, 32'h7F80_0000, 32'd0, 4'd9, 32'h0000_0080, 1'b0, 1'b1, w);
      issue(1'b1, FCVT_S_W, 32'hFFFF_FFF9, 32'd0, 4'd12, 32'hC0E0_0000, 1'b0, 1'b1, w);
      issue(1'b1, FCVT_S_WU, 32'hFFFF_FFFF, 32'd0, 4'd13, 32'h4F80_0000, 1'b0, 1'b1, w);
      drain();

      // Both requesters valid from reset: strict alternation at peak throughput.
      ops0[0] = '{cmd: ALU_ADD,   a: 32'h10,        b: 32'h20,        tag: 4'd0,  xd: 32'h30};
      ops0[1] = '{cmd: FSGNJ,     a: 32'h4049_0FDB, b: 32'h8000_0000, tag: 4'd1,  xd: 32'hC049_0FDB};
      ops0[2] = '{cmd: ALU_MV1,   a: 32'h1,         b: 32'hDEAD_BEEF, tag: 4'd2,  xd: 32'hDEAD_BEEF};
      ops0[3] = '{cmd: ALU_ADD,   a: 32'hFFFF_FFFF, b: 32'h1,         tag: 4'd3,  xd: 32'h0};
      ops1[0] = '{cmd: FCVT_S_W,  a: 32'h1,         b: 32'h0,         tag: 4'd8,  xd: 32'h3F80_0000};
      ops1[1] = '{cmd: FSGNJX,    a: 32'hBF80_0000, b: 32'h8000_0000, tag: 4'd9,  xd: 32'h3F80_0000};
      ops1[2] = '{cmd: FCLASS,    a: 32'h8000_0000, b: 32'h0,         tag: 4'd10, xd: 32'h8};
      ops1[3] = '{cmd: FCVT_WU_S, a: 32'h4120_0000, b: 32'h0,         tag: 4'd11, xd: 32'hA};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back('{id: 1'b0, tag: ops0[i].tag, data: ops0[i].xd, ill: 1'b0});
         exp_q.push_back('{id: 1'b1, tag: ops1[i].tag, data: ops1[i].xd, ill: 1'b0});
      end
      rst = 1'b1;
      drive(1'b0, 1'b1, ops0[0].cmd, ops0[0].a, ops0[0].b, ops0[0].tag);
      drive(1'b1, 1'b1, ops1[0].cmd, ops1[0].a, ops1[0].b, ops1[0].tag);
      @(posedge clk); #1;
      rst = 1'b0;
      i0 = 0; i1 = 0; cyc = 0;
      while ((i0 < 4 || i1 < 4) && cyc < 200) begin
         @(negedge clk);
         r0 = bus.req0_ready_o;
         r1 = bus.req1_ready_o;
         @(posedge clk); #1;
         cyc++;
         if (r0) begin
            i0++;
            if (i0 < 4) drive(1'b0, 1'b1, ops0[i0].cmd, ops0[i0].a, ops0[i0].b, ops0[i0].tag);
            else        drive(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, '0);
         end
         if (r1) begin
            i1++;
            if (i1 < 4) drive(1'b1, 1'b1, ops1[i1].cmd, ops1[i1].a, ops1[i1].b, ops1[i1].tag);
            else        drive(1'b1, 1'b0, 8'd0, 32'd0, 32'd0, '0);
         end
      end
      chk("alt_all_accepted", 32'(i0 + i1), 32'd8);
      chk("alt_cycles",       32'(cyc),     32'd22);
      drain();

      // Reset while in EXEC: op dropped, pointer back to requester 0.
      issue(1'b0, ALU_ADD, 32'd1, 32'd1, 4'd14, 32'd2, 1'b0, 1'b0, w);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 1'b1, ALU_ADD, 32'd2, 32'd2, 4'd1);
      drive(1'b1, 1'b1, ALU_ADD, 32'd3, 32'd3, 4'd2);
      @(negedge clk);
      chk("rst_exec_rsp_valid", 32'(bus.rsp_valid_o),  32'd0);
      chk("rst_exec_busy",      32'(bus.busy_o),       32'd0);
      chk("rst_exec_ready0",    32'(bus.req0_ready_o), 32'd1);
      chk("rst_exec_ready1",    32'(bus.req1_ready_o), 32'd0);
      drive(1'b0, 1'b0, 8'd0, 32'd0, 32'd0, '0);
      drive(1'b1, 1'b0, 8'd0, 32'd0, 32'd0, '0);
      repeat (4) @(negedge clk);
      chk("rst_exec_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      @(posedge clk); #1;

      // Reset while in RESP: pending response vanishes.
      bus.rsp_ready_i = 1'b0;
      issue(1'b1, ALU_ADD, 32'h40, 32'h2, 4'd11, 32'h42, 1'b0, 1'b0, w);
      @(negedge clk);
      @(negedge clk);
      chk("rst_resp_valid_before", 32'(bus.rsp_valid_o), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_resp_valid_after", 32'(bus.rsp_valid_o), 32'd0);
      chk("rst_resp_data_after",  bus.rsp_data_o,       32'd0);
      chk("rst_resp_busy_after",  32'(bus.busy_o),      32'd0);
      bus.rsp_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_resp_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
      @(posedge clk); #1;
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
